// File: rtl/case_3_mul_arb_if.sv
// Handshake bundle between two operand requesters, the shared multiplier
// arbiter and the result consumer.
interface case_3_mul_arb_if #(
  parameter int din0_WIDTH = 5,
  parameter int din1_WIDTH = 3,
  parameter int dout_WIDTH = 5
);
  logic                  req0_valid;
  logic [din0_WIDTH-1:0] req0_a;
  logic [din1_WIDTH-1:0] req0_b;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [din0_WIDTH-1:0] req1_a;
  logic [din1_WIDTH-1:0] req1_b;
  logic                  req1_ready;

  logic                  res_valid;
  logic                  res_ready;
  logic [dout_WIDTH-1:0] res_data;
  logic                  res_id;
  logic                  busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    input  res_ready,
    output res_valid, res_data, res_id, busy
  );

  // Requester / consumer side
  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    output res_ready,
    input  res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/case_3_mul_arb.sv
// Two-requester round-robin arbiter in front of one shared signed
// multiplier, with a single registered result slot that can be drained
// and reloaded on the same edge.
module case_3_mul_arb #(
  parameter int din0_WIDTH = 5,
  parameter int din1_WIDTH = 3,
  parameter int dout_WIDTH = 5
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  case_3_mul_arb_if.slave   bus
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                state;
  logic                  prio;
  logic [dout_WIDTH-1:0] data;
  logic                  id;

  logic       slot_free;
  logic       transfer;
  logic [1:0] valid;
  logic [1:0] gnt;

  logic [din0_WIDTH-1:0] mul_a;
  logic [din1_WIDTH-1:0] mul_b;
  logic signed [PW-1:0]  a_ext;
  logic signed [PW-1:0]  b_ext;
  logic signed [PW-1:0]  prod;
  logic [dout_WIDTH-1:0] result;
  logic                  unused_prod_hi;

  assign valid = {bus.req1_valid, bus.req0_valid};

  // Reset holds both readies low even though the slot looks empty.
  assign slot_free = !ap_rst && ((state == IDLE) || bus.res_ready);

  // A requester wins if it is the only one asking, or if the pointer favours it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign gnt[gi] = slot_free && valid[gi] &&
                       (!valid[1-gi] || (prio == 1'(gi)));
    end
  endgenerate

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign transfer       = |gnt;

  // Operand mux ahead of the single multiplier; the loser's operands never reach it.
  assign mul_a = gnt[1] ? bus.req1_a : bus.req0_a;
  assign mul_b = gnt[1] ? bus.req1_b : bus.req0_b;

  // Sign-extend both operands to the full product width before multiplying.
  assign a_ext  = {{din1_WIDTH{mul_a[din0_WIDTH-1]}}, mul_a};
  assign b_ext  = {{din0_WIDTH{mul_b[din1_WIDTH-1]}}, mul_b};
  assign prod   = a_ext * b_ext;
  assign result = prod[dout_WIDTH-1:0];

  // Upper product bits are dropped by the truncation.
  assign unused_prod_hi = ^prod[PW-1:dout_WIDTH];

  // Slot FSM: load on transfer, drain to IDLE when consumed with no reload.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
      data  <= '0;
      id    <= 1'b0;
      prio  <= 1'b0;
    end else if (transfer) begin
      state <= FULL;
      data  <= result;
      id    <= gnt[1];
      prio  <= gnt[0];
    end else if ((state == FULL) && bus.res_ready) begin
      state <= IDLE;
    end
  end

  assign bus.res_valid = (state == FULL);
  assign bus.busy      = (state == FULL);
  assign bus.res_data  = data;
  assign bus.res_id    = id;

endmodule

// File: doc/case_3_mul_arb.md
CASE_3_MUL_ARB -- requirements
Module: case_3_mul_arb

Interface
REQ-001 Parameter din0_WIDTH, default 5: width of signed multiplicand operand a.
REQ-002 Parameter din1_WIDTH, default 3: width of signed multiplier operand b.
REQ-003 Parameter dout_WIDTH, default 5: width of the truncated signed product.
REQ-004 ap_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 ap_rst  input  1  reset, asynchronous, active-high.
REQ-006 req0_valid  input  1  requester 0 presents an operand pair.
REQ-007 req0_a  input  din0_WIDTH  requester 0 operand a, signed.
REQ-008 req0_b  input  din1_WIDTH  requester 0 operand b, signed.
REQ-009 req0_ready  output  1  requester 0's pair is accepted this cycle.
REQ-010 req1_valid, req1_a, req1_b, req1_ready SHALL mirror REQ-006..REQ-009 for requester 1.
REQ-011 res_valid  output  1  res_data/res_id hold a valid result.
REQ-012 res_ready  input  1  consumer accepts the result this cycle.
REQ-013 res_data  output  dout_WIDTH  signed product, truncated.
REQ-014 res_id  output  1  index of the requester that produced res_data.
REQ-015 busy  output  1  equals res_valid.

Function
REQ-016 Block SHALL share one combinational signed multiplier between the two requesters and register its result in one output slot.
REQ-017 State: IDLE (slot empty) and FULL (slot holds result); res_valid=1 exactly in FULL.
REQ-018 Slot free this cycle SHALL be defined as (IDLE) or (FULL and res_ready=1).
REQ-019 Grant, when slot free: only req0_valid -> req0; only req1_valid -> req1; both -> requester indicated by round-robin pointer prio; neither -> no grant.
REQ-020 reqN_ready SHALL be 1 only for the granted requester and only while the slot is free; never both at once.
REQ-021 Transfer occurs when reqN_valid and reqN_ready are both 1 at a rising edge.
REQ-022 On transfer: res_data <= low dout_WIDTH bits of the full-width (din0_WIDTH+din1_WIDTH) two's-complement product of signed reqN_a by signed reqN_b; res_id <= N; state <= FULL.
REQ-023 On transfer: prio <= the non-granted index; prio SHALL NOT change without a transfer.
REQ-024 Latency: result visible on res_valid/res_data exactly 1 cycle after transfer edge.
REQ-025 FULL and res_ready=1 with no transfer -> state <= IDLE; res_data/res_id retain last value.
REQ-026 FULL and res_ready=1 with transfer -> state stays FULL, slot reloaded same edge (no bubble); sustained throughput 1 result/cycle.
REQ-027 FULL and res_ready=0 -> both readies 0; res_data, res_id, prio stable.
REQ-028 Operand inputs of a non-granted requester SHALL have no effect on any output or state.

Reset
REQ-029 ap_rst=1 SHALL immediately, without waiting for ap_clk, force: state IDLE, res_valid=0, busy=0, res_data=0, res_id=0, prio=0 (req0 first).
REQ-030 While ap_rst=1, req0_ready and req1_ready SHALL be 0; a pending result is discarded.
REQ-031 First rising edge after ap_rst deasserts SHALL be able to perform a transfer.

Verification
REQ-032 After reset, req0 a=5'd3 b=3'd2, req1 idle, res_ready=1 -> next cycle res_valid=1, res_data=5'd6, res_id=0; following cycle res_valid=0.
REQ-033 req1 a=5'b11101 (-3) b=3'b011 (3) -> res_data=5'b10111 (low 5 bits of -9), res_id=1; req0 a=5'b10000 (-16) b=3'b100 (-4) -> res_data=5'b00000 (64 truncated).
REQ-034 Both requesters valid continuously, res_ready=1 -> res_id sequence 0,1,0,1,... one result per cycle, no idle cycle.
REQ-035 res_ready=0 while FULL for 3 cycles with both requesters valid -> readies 0, res_data/res_id unchanged; on res_ready=1 the next result loads the same edge.
REQ-036 ap_rst pulsed mid-cycle while FULL with prio=1 -> res_valid drops before next ap_clk edge, res_data=0; after release, both valid -> first grant to req0.
